// File: rtl/vx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : vx_mem_responder
// Brief    : Fixed-latency, in-order, tag-preserving memory responder for the
//            Vortex memory request/response ports, backed by a line store.
//            Optional bounds checking: define VX_MEM_RSP_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vx_mem_responder #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 26,
    parameter int TAG_WIDTH   = 8,
    parameter int MEM_LINES   = 1024,
    parameter int RSP_LATENCY = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [DATA_WIDTH-1:0]   mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic                    busy,
    output logic                    mem_err
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_IDX_W = $clog2(MEM_LINES);
    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_CD_W  = $clog2(RSP_LATENCY + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_CD_W-1:0]  c_LAT   = c_CD_W'(RSP_LATENCY);

    logic [DATA_WIDTH-1:0] r_store [MEM_LINES];

    logic [DATA_WIDTH-1:0] r_q_data [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0]  r_q_tag  [QUEUE_DEPTH];
    logic [c_CD_W-1:0]     r_q_cd   [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_req_en;

    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_addr_hi;
    logic                  w_oor;
    logic                  w_req_fire;
    logic                  w_wr_en;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_idx = mem_req_addr[c_IDX_W-1:0];

    generate
        if (ADDR_WIDTH > c_IDX_W) begin : g_hi_addr
            assign w_addr_hi = |mem_req_addr[ADDR_WIDTH-1:c_IDX_W];
        end else begin : g_no_hi_addr
            assign w_addr_hi = 1'b0;
        end
    endgenerate

`ifdef VX_MEM_RSP_BOUNDS_CHECK_EN
    logic r_mem_err;

    assign w_oor = w_addr_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_err <= 1'b0;
        end else if (w_req_fire && w_oor) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err;
`else
    // Upper address bits alias onto the store; they are deliberately ignored.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = w_addr_hi;
    assign w_oor            = 1'b0;
    assign mem_err          = 1'b0;
`endif

    // Ready comes only from registered state; r_req_en keeps it low during
    // reset and for the first cycle after release.
    assign mem_req_ready = r_req_en && (r_count < c_DEPTH);
    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign w_wr_en       = w_req_fire && mem_req_rw && !w_oor;
    assign w_push        = w_req_fire && !mem_req_rw;
    assign w_rd_data     = w_oor ? '0 : r_store[w_idx];

    assign w_rsp_valid   = (r_count != '0) && (r_q_cd[r_rd_ptr] == '0);
    assign w_pop         = w_rsp_valid && mem_rsp_ready;

    assign mem_rsp_valid = w_rsp_valid;
    assign mem_rsp_data  = w_rsp_valid ? r_q_data[r_rd_ptr] : '0;
    assign mem_rsp_tag   = w_rsp_valid ? r_q_tag[r_rd_ptr]  : '0;
    assign busy          = (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (mem_req_byteen[b]) begin
                    r_store[w_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
    end

    // Payload is captured at accept so later writes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= w_rd_data;
            r_q_tag[r_wr_ptr]  <= mem_req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_cd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
                    r_q_cd[i] <= c_LAT;
                end else if (r_q_cd[i] != '0) begin
                    r_q_cd[i] <= r_q_cd[i] - c_CD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_req_en <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_mem_responder
// Brief    : Scoreboard bench for vx_mem_responder; directed stimulus with
//            hand-computed expected read data and tags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_mem_responder;

    localparam int DW  = 512;
    localparam int AW  = 26;
    localparam int TW  = 8;
    localparam int LAT = 4;
    localparam int QD  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_req_valid;
    logic          mem_req_rw;
    logic [DW/8-1:0] mem_req_byteen;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [TW-1:0] mem_req_tag;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic [TW-1:0] mem_rsp_tag;
    logic          mem_rsp_ready;
    logic          busy;
    logic          mem_err;

    vx_mem_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TAG_WIDTH  (TW),
        .MEM_LINES  (1024),
        .RSP_LATENCY(LAT),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_rw    (mem_req_rw),
        .mem_req_byteen(mem_req_byteen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_ready (mem_rsp_ready),
        .busy          (busy),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            acc;
        bit            exact;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   nc    = 0;

    localparam logic [DW-1:0] c_A5   = {64{8'hA5}};
    localparam logic [DW-1:0] c_3C   = {64{8'h3C}};
    localparam logic [DW-1:0] c_FF   = {64{8'hFF}};
    localparam logic [DW-1:0] c_MIX  = {{63{8'hFF}}, 8'h00};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every handshake is compared against the head of the scoreboard.
    always @(negedge clk) begin
        nc++;
        if (mem_rsp_valid === 1'b1 && mem_rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got tag %0h want none", mem_rsp_tag);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", mem_rsp_data, e.data);
                chk("rsp_tag", DW'(mem_rsp_tag), DW'(e.tag));
                if (e.exact) begin
                    chk("rsp_latency", DW'(nc - e.acc), DW'(LAT));
                end else begin
                    total++;
                    if (nc - e.acc < LAT) begin
                        bad++;
                        $display("FAIL rsp_early: got %0d want >=%0d", nc - e.acc, LAT);
                    end
                end
            end
        end
    end

    task automatic req(input bit rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW/8-1:0] be, input logic [TW-1:0] tag,
                       output bit ok, output int acc);
        int n;
        n  = 0;
        ok = 1'b0;
        acc = 0;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_data   = data;
        mem_req_byteen = be;
        mem_req_tag    = tag;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (mem_req_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            n++;
        end
        acc = nc + 1;
        #1 mem_req_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no accept want accept of tag %0h", tag);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] be);
        bit ok;
        int acc;
        req(1'b1, addr, data, be, '0, ok, acc);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] exp_data, input bit exact);
        bit   ok;
        int   acc;
        exp_t x;
        req(1'b0, addr, '0, '0, tag, ok, acc);
        if (ok) begin
            x.data  = exp_data;
            x.tag   = tag;
            x.acc   = acc;
            x.exact = exact;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        mem_req_valid  = 1'b0;
        mem_req_rw     = 1'b0;
        mem_req_byteen = '0;
        mem_req_addr   = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
        mem_rsp_ready  = 1'b1;

        // Reset state
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", DW'(mem_req_ready), '0);
        chk("rst_rsp_valid", DW'(mem_rsp_valid), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_mem_err", DW'(mem_err), '0);
        chk("rst_rsp_data", mem_rsp_data, '0);
        chk("rst_rsp_tag", DW'(mem_rsp_tag), '0);
        reset = 1'b0;
        #1 chk("rel_ready_low", DW'(mem_req_ready), '0);
        @(negedge clk);
        chk("rel_ready_high", DW'(mem_req_ready), DW'(1));
        @(posedge clk);
        #1;

        // Write then read back-to-back with exact latency
        do_write(AW'(16), c_A5, '1);
        do_read(AW'(16), TW'(8'h2A), c_A5, 1'b1);
        @(negedge clk);
        chk("busy_after_read", DW'(busy), DW'(1));
        drain();
        @(negedge clk);
        chk("busy_after_drain", DW'(busy), '0);
        @(posedge clk);
        #1;

        // Byte-enable merge; zero byteen leaves the line unchanged
        do_write(AW'(32), c_FF, '1);
        do_write(AW'(32), '0, 64'h1);
        do_write(AW'(32), c_3C, '0);
        do_read(AW'(32), TW'(8'h11), c_MIX, 1'b1);
        drain();

        // Backpressure: four accepted, fifth held off, head stable
        mem_rsp_ready = 1'b0;
        do_read(AW'(16), TW'(1), c_A5, 1'b0);
        do_read(AW'(32), TW'(2), c_MIX, 1'b0);
        do_read(AW'(16), TW'(3), c_A5, 1'b0);
        do_read(AW'(32), TW'(4), c_MIX, 1'b0);
        fork
            do_read(AW'(16), TW'(5), c_A5, 1'b0);
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("full_ready_low", DW'(mem_req_ready), '0);
                    chk("stall_valid", DW'(mem_rsp_valid), DW'(1));
                    chk("stall_tag", DW'(mem_rsp_tag), DW'(1));
                    chk("stall_data", mem_rsp_data, c_A5);
                end
                @(posedge clk);
                #1 mem_rsp_ready = 1'b1;
            end
        join
        drain();

        // Out-of-range read
        do_write(AW'(0), c_3C, '1);
`ifdef VX_MEM_RSP_BOUNDS_CHECK_EN
        do_read(AW'(1024), TW'(8'h77), '0, 1'b1);
        drain();
        chk("mem_err_set", DW'(mem_err), DW'(1));
        do_read(AW'(16), TW'(8'h78), c_A5, 1'b1);
        drain();
        chk("mem_err_sticky", DW'(mem_err), DW'(1));
`else
        do_read(AW'(1024), TW'(8'h77), c_3C, 1'b1);
        drain();
        chk("mem_err_zero", DW'(mem_err), '0);
`endif

        // Reset with three reads in flight
        do_read(AW'(16), TW'(8'h61), c_A5, 1'b0);
        do_read(AW'(16), TW'(8'h62), c_A5, 1'b0);
        do_read(AW'(16), TW'(8'h63), c_A5, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", DW'(mem_rsp_valid), '0);
        chk("midrst_busy", DW'(busy), '0);
        chk("midrst_ready", DW'(mem_req_ready), '0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", DW'(mem_rsp_valid), '0);
        end
        @(posedge clk);
        #1;
        do_read(AW'(16), TW'(8'h99), c_A5, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
